// File: rtl/exp_taylor_arb_pkg.sv
// Shared types and widths for the exponential-unit arbiter slice.
package exp_taylor_pkg;

  localparam int unsigned EXP_IN_W  = 12;
  localparam int unsigned EXP_OUT_W = 20;

  typedef logic [EXP_IN_W-1:0]  exp_in_t;
  typedef logic [EXP_OUT_W-1:0] exp_out_t;

  typedef enum logic {ST_RUN, ST_DRAIN} arb_state_t;

endpackage

// File: rtl/exp_taylor_arb_if.sv
// Requester and exp-unit signal bundle for exp_taylor_arb; slave = arbiter side.
interface exp_taylor_arb_if #(parameter int unsigned NREQ = 4) ();
  import exp_taylor_pkg::*;

  logic [NREQ-1:0]          iReq;
  logic [NREQ*EXP_IN_W-1:0] iData;
  logic [NREQ-1:0]          oGnt;
  exp_in_t                  oExpData;
  logic                     oExpDataValid;
  exp_out_t                 iExpData;
  logic                     iExpDataValid;
  exp_out_t                 oData;
  logic [NREQ-1:0]          oDataValid;
  logic                     iFlush;
  logic                     oFlushDone;
  logic                     oErr;

  modport slave (
    input  iReq, iData, iExpData, iExpDataValid, iFlush,
    output oGnt, oExpData, oExpDataValid, oData, oDataValid, oFlushDone, oErr
  );

  modport master (
    output iReq, iData, iExpData, iExpDataValid, iFlush,
    input  oGnt, oExpData, oExpDataValid, oData, oDataValid, oFlushDone, oErr
  );

endinterface

// File: rtl/exp_tag_fifo.sv
// Synchronous FIFO holding requester tags of in-flight exp operations.
module exp_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [TAG_W-1:0]       pushTag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       popTag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushTag;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign popTag = mem[rdPtr];
  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/exp_taylor_arb.sv
// Shares one pipelined exp unit among NREQ requesters; results routed back by queued tag.
// EXP_ARB_FIXED_PRIO_EN: lowest-index-wins priority instead of round-robin.
module exp_taylor_arb
  import exp_taylor_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  exp_taylor_arb_if.slave  bus
);

  localparam int unsigned TAG_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  arb_state_t       state;
  exp_in_t          slot [NREQ];
  logic [TAG_W-1:0] winIdx;
  logic             winValid;
  logic             grant;
  logic             pop;
  logic             drainDone;
  logic [TAG_W-1:0] headTag;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;

  exp_in_t          expDataQ;
  logic             expDataValidQ;
  exp_out_t         dataQ;
  logic [NREQ-1:0]  dataValidQ;
  logic             flushDoneQ;
  logic             errQ;

  for (genvar k = 0; k < NREQ; k++) begin : g_slot
    assign slot[k] = bus.iData[k*EXP_IN_W +: EXP_IN_W];
  end

`ifdef EXP_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest asserted index is the last one written.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (bus.iReq[TAG_W'(i)]) begin
        winValid = 1'b1;
        winIdx   = TAG_W'(i);
      end
    end
  end
`else
  logic [TAG_W-1:0] rrPtr;
  logic [TAG_W-1:0] idx;

  // Descending scan from rrPtr so the nearest requester at or after it wins.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    idx      = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      idx = TAG_W'((int'(rrPtr) + i) % int'(NREQ));
      if (bus.iReq[idx]) begin
        winValid = 1'b1;
        winIdx   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rrPtr <= '0;
    else if (grant) rrPtr <= (int'(winIdx) == int'(NREQ) - 1) ? '0 : winIdx + TAG_W'(1);
  end
`endif

  assign pop       = bus.iExpDataValid && !empty;
  assign grant     = winValid && (state == ST_RUN) && !bus.iFlush && (!full || pop);
  assign drainDone = (state == ST_DRAIN) && (count == '0) && !pop;

  exp_tag_fifo #(.DEPTH(TAG_DEPTH), .TAG_W(TAG_W)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (grant),
    .pushTag (winIdx),
    .pop     (pop),
    .popTag  (headTag),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Run/drain FSM plus issue and return registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      expDataQ      <= '0;
      expDataValidQ <= 1'b0;
      dataQ         <= '0;
      dataValidQ    <= '0;
      flushDoneQ    <= 1'b0;
      errQ          <= 1'b0;
    end else begin
      expDataValidQ <= grant;
      if (grant) expDataQ <= slot[winIdx];
      dataValidQ    <= pop ? (NREQ'(1) << headTag) : '0;
      if (pop) dataQ <= bus.iExpData;
      if (bus.iExpDataValid && empty) errQ <= 1'b1;
      flushDoneQ    <= drainDone;
      case (state)
        ST_RUN:   if (bus.iFlush) state <= ST_DRAIN;
        ST_DRAIN: if (drainDone)  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign bus.oGnt          = grant ? (NREQ'(1) << winIdx) : '0;
  assign bus.oExpData      = expDataQ;
  assign bus.oExpDataValid = expDataValidQ;
  assign bus.oData         = dataQ;
  assign bus.oDataValid    = dataValidQ;
  assign bus.oFlushDone    = flushDoneQ;
  assign bus.oErr          = errQ;

endmodule

// File: tb/tb_exp_taylor_arb.sv
// Directed bench for exp_taylor_arb with a modelled exp unit (operand+1000, variable latency).
module tb_exp_taylor_arb;

`ifdef EXP_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic spur;
  int   lat;
  int   nCmp;
  int   nErr;
  int   ops [4];

  logic [11:0] pipeOp [16];
  logic        pipeV  [16];

  exp_taylor_arb_if #(.NREQ(4)) bus ();

  exp_taylor_arb #(.NREQ(4), .TAG_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exp unit model: shift register, tap at lat-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) begin
        pipeV[k]  <= 1'b0;
        pipeOp[k] <= '0;
      end
    end else begin
      pipeV[0]  <= bus.oExpDataValid;
      pipeOp[0] <= bus.oExpData;
      for (int k = 1; k < 16; k++) begin
        pipeV[k]  <= pipeV[k-1];
        pipeOp[k] <= pipeOp[k-1];
      end
    end
  end

  assign bus.iExpDataValid = pipeV[lat-1] | spur;
  assign bus.iExpData      = {8'd0, pipeOp[lat-1]} + 20'd1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n         = 1'b0;
    spur          = 1'b0;
    bus.iReq      = '0;
    bus.iData     = '0;
    bus.iFlush    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt",  32'(bus.oGnt), 0);
    chk("rst_xv",   32'(bus.oExpDataValid), 0);
    chk("rst_xd",   32'(bus.oExpData), 0);
    chk("rst_dv",   32'(bus.oDataValid), 0);
    chk("rst_data", 32'(bus.oData), 0);
    chk("rst_fd",   32'(bus.oFlushDone), 0);
    chk("rst_err",  32'(bus.oErr), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    nCmp = 0;
    nErr = 0;
    lat  = 4;
    ops  = '{384, 736, 100, 200};

    // Single op: grant same cycle, operand next cycle, result 6 cycles after grant.
    doReset();
    bus.iReq        = 4'b0001;
    bus.iData[11:0] = 12'd384;
    @(negedge clk); chk("t1_gnt", 32'(bus.oGnt), 1);
    nxt(); bus.iReq = '0;
    @(negedge clk);
    chk("t1_xd", 32'(bus.oExpData), 384);
    chk("t1_xv", 32'(bus.oExpDataValid), 1);
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge clk); chk("t1_dv_early", 32'(bus.oDataValid), 0);
    end
    nxt(); @(negedge clk);
    chk("t1_dv",   32'(bus.oDataValid), 1);
    chk("t1_data", 32'(bus.oData), 1384);
    nxt(); @(negedge clk);
    chk("t1_dv_end",   32'(bus.oDataValid), 0);
    chk("t1_data_hold", 32'(bus.oData), 1384);

    // All four requesting, each drops when granted.
    doReset();
    bus.iReq = 4'b1111;
    for (int i = 0; i < 4; i++) bus.iData[12*i +: 12] = 12'(ops[i]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_gnt", 32'(bus.oGnt), 32'(1) << i);
      nxt(); bus.iReq[i] = 1'b0;
    end
    @(negedge clk); chk("t2_dv_idle", 32'(bus.oDataValid), 0);
    nxt(); @(negedge clk); chk("t2_dv_idle", 32'(bus.oDataValid), 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge clk);
      chk("t2_dv",   32'(bus.oDataValid), 32'(1) << i);
      chk("t2_data", 32'(bus.oData), 32'(ops[i] + 1000));
    end

    // Fairness with req0 and req2 held high.
    doReset();
    bus.iReq = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_gnt", 32'(bus.oGnt), (FIXED || (i % 2 == 0)) ? 32'd1 : 32'd4);
      nxt();
    end

    // Backpressure: latency 12, eight in flight fill the tag FIFO.
    doReset();
    lat      = 12;
    bus.iReq = 4'b1111;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 13)     chk("t4_gnt_ret",  32'(bus.oGnt), 1);
      else if (i < 8)  chk("t4_gnt",      32'(bus.oGnt), FIXED ? 32'd1 : (32'(1) << (i % 4)));
      else             chk("t4_gnt_full", 32'(bus.oGnt), 0);
      nxt();
    end

    // Flush with three ops in flight.
    doReset();
    lat      = 4;
    bus.iReq = 4'b0111;
    for (int i = 0; i < 3; i++) bus.iData[12*i +: 12] = 12'(10 * (i + 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t5_gnt", 32'(bus.oGnt), 32'(1) << i);
      nxt(); bus.iReq[i] = 1'b0;
    end
    bus.iReq   = 4'b1111;
    bus.iFlush = 1'b1;
    @(negedge clk); chk("t5_gnt_flush", 32'(bus.oGnt), 0);
    nxt(); bus.iFlush = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("t5_gnt_drain", 32'(bus.oGnt), 0);
      chk("t5_fd_early",  32'(bus.oFlushDone), 0);
      chk("t5_dv",        32'(bus.oDataValid), (j < 2) ? 32'd0 : (32'(1) << (j - 2)));
      nxt();
    end
    bus.iReq = '0;
    @(negedge clk); chk("t5_fd", 32'(bus.oFlushDone), 1);
    nxt(); @(negedge clk); chk("t5_fd_end", 32'(bus.oFlushDone), 0);

    // Flush while idle: pulse two cycles after iFlush.
    doReset();
    bus.iFlush = 1'b1;
    @(negedge clk);
    nxt(); bus.iFlush = 1'b0;
    @(negedge clk); chk("t5i_fd_early", 32'(bus.oFlushDone), 0);
    nxt(); @(negedge clk); chk("t5i_fd", 32'(bus.oFlushDone), 1);
    nxt(); @(negedge clk); chk("t5i_fd_end", 32'(bus.oFlushDone), 0);

    // Spurious result with empty tag FIFO sets sticky oErr.
    doReset();
    spur = 1'b1;
    @(negedge clk);
    nxt(); spur = 1'b0;
    @(negedge clk);
    chk("t6_err", 32'(bus.oErr), 1);
    chk("t6_dv",  32'(bus.oDataValid), 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); @(negedge clk); chk("t6_err_sticky", 32'(bus.oErr), 1);
    end
    doReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
